// File: rtl/main_mem_pkg.sv
// Shared definitions for the main-memory read responder.
//   mm_state_t      : responder FSM states (IDLE, WAIT, RESP)
//   MEM_BAD_DATA    : word returned for out-of-range reads
//   DEF_*           : default parameter values for the responder
//   word_in_range() : true when a byte address maps into the backing store
package main_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mm_state_t;

   localparam logic [31:0] MEM_BAD_DATA    = 32'hDEAD_BEEF;
   localparam int          DEF_LATENCY     = 4;
   localparam int          DEF_QDEPTH      = 4;
   localparam int          DEF_DEPTH_WORDS = 1024;

   // Word index is addr[31:2]; compared at full width so any DEPTH_WORDS works.
   function automatic logic word_in_range(input logic [31:0] addr,
                                          input logic [31:0] depth_words);
      return ({2'b00, addr[31:2]} < depth_words);
   endfunction

endpackage

// File: rtl/main_mem_req_fifo.sv
// Pending-request FIFO for the main-memory responder.
//   clk, rst (sync, active-low)
//   push/din  : enqueue din (ignored when full)
//   pop       : dequeue head (ignored when empty)
//   full/empty: occupancy flags, derived from the registered count
//   head      : oldest entry
module req_fifo #(
   parameter int QDEPTH = 4,
   parameter int WIDTH  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int PW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CNTW = $clog2(QDEPTH) + 1;

   logic [WIDTH-1:0] slots [QDEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CNTW-1:0]  count;
   logic             do_push;
   logic             do_pop;

   // Explicit wrap keeps the pointers QDEPTH-modulo for any depth.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count == CNTW'(QDEPTH));
   assign empty   = (count == '0);
   assign head    = slots[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked by count.
   always_ff @(posedge clk) begin
      if (do_push) slots[wr_ptr] <= din;
   end

endmodule

// File: rtl/main_mem_responder.sv
// Fixed-latency main-memory read responder with a preloadable backing store.
//   clk, rst (sync, active-low)
//   mem_req_valid/mem_req_addr : read request (byte address)
//   mem_resp_valid/mem_resp_data: one-cycle response strobe and word
//   mem_req_full               : pending FIFO full, request this cycle dropped
//   busy                       : FSM not idle or requests queued
//   init_we/init_addr/init_data: backdoor word write for preload
//   drop_cnt                   : saturating count of dropped requests
//   addr_err                   : sticky out-of-range read flag
// Requires LATENCY >= 1 and power-of-two DEPTH_WORDS / QDEPTH.
module main_mem_responder
   import main_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
   parameter int LATENCY     = DEF_LATENCY,
   parameter int QDEPTH      = DEF_QDEPTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_req_valid,
   input  logic [31:0] mem_req_addr,
   output logic        mem_resp_valid,
   output logic [31:0] mem_resp_data,
   output logic        mem_req_full,
   output logic        busy,
   input  logic        init_we,
   input  logic [31:0] init_addr,
   input  logic [31:0] init_data,
   output logic [7:0]  drop_cnt,
   output logic        addr_err
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   mm_state_t   state, state_nxt;
   logic [CW-1:0] cnt;
   logic [31:0] cur_addr;
   logic [31:0] mem [DEPTH_WORDS];

   logic        accept;
   logic        start;
   logic [31:0] start_addr;
   logic        push;
   logic        pop;
   logic        resp_fire;
   logic        fifo_full;
   logic        fifo_empty;
   logic [31:0] fifo_head;
   logic        cur_in_range;
   logic        init_in_range;
   logic [AW-1:0] cur_idx;
   logic [AW-1:0] init_idx;

   assign accept        = mem_req_valid && !mem_req_full;
   assign mem_req_full  = fifo_full;
   assign busy          = (state != IDLE) || !fifo_empty;
   assign cur_in_range  = word_in_range(cur_addr, 32'(DEPTH_WORDS));
   assign init_in_range = word_in_range(init_addr, 32'(DEPTH_WORDS));
   assign cur_idx       = cur_addr[AW+1:2];
   assign init_idx      = init_addr[AW+1:2];

   req_fifo #(
      .QDEPTH (QDEPTH),
      .WIDTH  (32)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (mem_req_addr),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // IDLE and RESP are both slots where a new request may start: the queue
   // head has priority; with an empty queue a fresh request bypasses it.
   always_comb begin
      state_nxt  = state;
      start      = 1'b0;
      start_addr = mem_req_addr;
      push       = 1'b0;
      pop        = 1'b0;
      resp_fire  = 1'b0;
      case (state)
         IDLE, RESP: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               start      = 1'b1;
               start_addr = fifo_head;
               push       = accept;
            end else if (accept) begin
               start = 1'b1;
            end
            state_nxt = start ? WAIT : IDLE;
         end
         WAIT: begin
            push = accept;
            if (cnt == '0) begin
               resp_fire = 1'b1;
               state_nxt = RESP;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt            <= '0;
         cur_addr       <= '0;
         mem_resp_valid <= 1'b0;
         mem_resp_data  <= '0;
         drop_cnt       <= '0;
         addr_err       <= 1'b0;
      end else begin
         mem_resp_valid <= resp_fire;
         if (start) begin
            cnt      <= CW'(LATENCY - 1);
            cur_addr <= start_addr;
         end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
         // Read sits in the same edge as any backdoor write, so a colliding
         // write is seen only by later reads.
         if (resp_fire) begin
            if (cur_in_range) begin
               mem_resp_data <= mem[cur_idx];
            end else begin
               mem_resp_data <= MEM_BAD_DATA;
               addr_err      <= 1'b1;
            end
         end
         if (mem_req_valid && mem_req_full && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
      end
   end

   // Backing store is never reset.
   always_ff @(posedge clk) begin
      if (init_we && init_in_range) mem[init_idx] <= init_data;
   end

endmodule

// File: tb/tb_main_mem_responder.sv
module tb_main_mem_responder;

   localparam int L  = 4;
   localparam int QD = 4;
   localparam int DW = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        mem_req_full;
   logic        busy;
   logic        init_we;
   logic [31:0] init_addr;
   logic [31:0] init_data;
   logic [7:0]  drop_cnt;
   logic        addr_err;

   main_mem_responder dut (
      .clk            (clk),
      .rst            (rst),
      .mem_req_valid  (mem_req_valid),
      .mem_req_addr   (mem_req_addr),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .mem_req_full   (mem_req_full),
      .busy           (busy),
      .init_we        (init_we),
      .init_addr      (init_addr),
      .init_data      (init_data),
      .drop_cnt       (drop_cnt),
      .addr_err       (addr_err)
   );

   always #5 clk = ~clk;

   // Reference model: each accepted request gets a start edge
   // max(accept edge, previous start + L + 1) and responds at start + L.
   typedef struct {
      logic [31:0] addr;
      int          start;
   } mreq_t;

   mreq_t       pq[$];
   logic [31:0] mm [0:DW-1];
   int          cyc        = 0;
   int          last_start = -100;
   int          m_drop     = 0;
   bit          m_err      = 0;
   logic [31:0] m_data     = '0;
   int          n_chk      = 0;
   int          n_fail     = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step(input bit v, input logic [31:0] a, input bit we,
                       input logic [31:0] ia, input logic [31:0] id, input bit rn);
      int   nq;
      int   st;
      bit   fired;
      bit   m_full;
      logic [29:0] idx;
      mem_req_valid = v;
      mem_req_addr  = a;
      init_we       = we;
      init_addr     = ia;
      init_data     = id;
      rst           = rn;
      @(posedge clk);
      cyc++;
      fired = 0;
      if (!rn) begin
         pq.delete();
         last_start = -100;
         m_drop     = 0;
         m_err      = 0;
         m_data     = '0;
      end else begin
         nq = 0;
         foreach (pq[i]) if (pq[i].start >= cyc) nq++;
         if (v) begin
            if (nq == QD) begin
               if (m_drop < 255) m_drop++;
            end else begin
               st = (cyc > last_start + L + 1) ? cyc : last_start + L + 1;
               pq.push_back('{addr: a, start: st});
               last_start = st;
            end
         end
         if (pq.size() > 0 && pq[0].start + L == cyc) begin
            fired = 1;
            idx   = pq[0].addr[31:2];
            if (idx < DW) m_data = mm[idx];
            else begin
               m_data = 32'hDEAD_BEEF;
               m_err  = 1;
            end
            void'(pq.pop_front());
         end
      end
      if (we && ia[31:2] < DW) mm[ia[31:2]] = id;
      nq = 0;
      foreach (pq[i]) if (pq[i].start > cyc) nq++;
      m_full = (nq == QD);
      #1;
      chk("resp_valid", {31'd0, mem_resp_valid}, {31'd0, fired});
      if (fired || !rn) chk("resp_data", mem_resp_data, m_data);
      chk("req_full", {31'd0, mem_req_full}, {31'd0, m_full});
      chk("busy", {31'd0, busy}, {31'd0, (pq.size() > 0) || fired});
      chk("drop_cnt", {24'd0, drop_cnt}, 32'(m_drop));
      chk("addr_err", {31'd0, addr_err}, {31'd0, m_err});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, '0, 0, '0, '0, 1);
   endtask

   task automatic rd(input logic [31:0] a);
      step(1, a, 0, '0, '0, 1);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      step(0, '0, 1, a, d, 1);
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] wa;
      bit          rv, rw, rr;

      step(0, '0, 0, '0, '0, 0);
      step(0, '0, 0, '0, '0, 0);

      // Preload the low 64 words; reads below stay within this region.
      for (int w = 0; w < 64; w++) wr(32'(w) << 2, $urandom);
      wr(32'h0000_0040, 32'h1234_5678);
      wr(32'h0000_0000, 32'd1);
      wr(32'h0000_0004, 32'd2);
      wr(32'h0000_0008, 32'd3);
      wr(32'h0000_2000, 32'hFFFF_FFFF);  // out-of-range write: ignored, no addr_err
      idle(1);

      // Single read: response visible after E0+4.
      rd(32'h0000_0040);
      idle(3);
      step(0, '0, 0, '0, '0, 1);
      chk("single_valid", {31'd0, mem_resp_valid}, 32'd1);
      chk("single_data", mem_resp_data, 32'h1234_5678);
      idle(3);

      // Burst of three, responses 1,2,3 spaced L+1.
      rd(32'h0); rd(32'h4); rd(32'h8);
      idle(20);

      // Overflow: five accepted, sixth dropped.
      for (int i = 0; i < 5; i++) rd(32'(i) << 2);
      chk("ovf_full", {31'd0, mem_req_full}, 32'd1);
      rd(32'h14);
      chk("ovf_drop", {24'd0, drop_cnt}, 32'd1);
      idle(30);

      // Out-of-range read, then a valid one; flag must stay set.
      rd(32'h0000_1000);
      idle(4);
      chk("oor_data", mem_resp_data, 32'hDEAD_BEEF);
      rd(32'h0000_0041);
      idle(6);
      chk("oor_sticky", {31'd0, addr_err}, 32'd1);

      // Reset while serving with two queued.
      rd(32'h0); rd(32'h4); rd(32'h8);
      idle(1);
      step(0, '0, 0, '0, '0, 0);
      idle(10);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
      rd(32'h0000_0040);
      idle(4);
      chk("rst_fresh", mem_resp_data, 32'h1234_5678);
      idle(2);

      // Collision: write lands on the WAIT->RESP edge of the same word.
      wr(32'h0000_0040, 32'h5555_5555);
      rd(32'h0000_0040);
      idle(3);
      wr(32'h0000_0040, 32'hAAAA_AAAA);
      chk("coll_old", mem_resp_data, 32'h5555_5555);
      rd(32'h0000_0040);
      idle(4);
      chk("coll_new", mem_resp_data, 32'hAAAA_AAAA);
      idle(2);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         rv = ($urandom_range(0, 99) < 60);
         rw = ($urandom_range(0, 99) < 20);
         rr = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 15) == 0)
            ra = 32'h0000_1000 + ($urandom_range(0, 4095) << 2);
         else
            ra = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0)
            wa = 32'h8000_0000 | $urandom;
         else
            wa = 32'($urandom_range(0, 63)) << 2;
         step(rv, ra, rw, wa, $urandom, rr);
      end
      idle(30);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
